// File: rtl/bt656_capture_ctrl.sv
// Per-frame capture sequencer for decoded BT.656 video: field select, window crop,
// write request/ack handshake and four-deep frame-buffer index rotation.
module bt656_capture_ctrl #(
  parameter int unsigned H_START   = 7,
  parameter int unsigned H_ACTIVE  = 480,
  parameter int unsigned V_START   = 0,
  parameter int unsigned V_ACTIVE  = 272,
  parameter bit          FIELD_SEL = 1'b0,
  parameter int unsigned CNT_W     = 11
) (
  input  logic        bt656_clk,
  input  logic        rst_n,
  input  logic        vid_h,
  input  logic        vid_v,
  input  logic        vid_f,
  input  logic [15:0] pix_rgb,
  output logic        write_req,
  input  logic        write_req_ack,
  output logic        write_en,
  output logic [15:0] write_data,
  output logic [1:0]  write_addr_index,
  output logic [1:0]  read_addr_index,
  output logic [15:0] frames_done,
  output logic [7:0]  frames_dropped
);

  localparam int unsigned FRAME_PIX = H_ACTIVE * V_ACTIVE;
  localparam int unsigned PIX_W     = $clog2(FRAME_PIX + 1);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] H_LO    = CNT_W'(H_START);
  localparam logic [CNT_W-1:0] H_HI    = CNT_W'(H_START + H_ACTIVE);
  localparam logic [CNT_W-1:0] V_LO    = CNT_W'(V_START + 1);
  localparam logic [CNT_W-1:0] V_HI    = CNT_W'(V_START + V_ACTIVE);
  localparam logic [PIX_W-1:0] PIX_MAX = '1;
  localparam logic [PIX_W-1:0] PIX_END = PIX_W'(FRAME_PIX);

  typedef enum logic [1:0] {StIdle, StReq, StArmed, StActive} state_e;

  state_e             state_q, state_d;
  logic               h_d_q, v_d_q;
  logic [CNT_W-1:0]   hcnt_q, hcnt_d;
  logic [CNT_W-1:0]   vcnt_q, vcnt_d;
  logic [PIX_W-1:0]   pix_cnt_q, pix_cnt_d;
  logic               write_req_q, write_req_d;
  logic               write_en_q, write_en_d;
  logic [15:0]        write_data_q, write_data_d;
  logic [1:0]         widx_q, widx_d;
  logic [1:0]         ridx_q, ridx_d;
  logic [15:0]        done_q, done_d;
  logic [7:0]         drop_q, drop_d;

  logic v_rise, v_fall, h_fall, field_match, in_window;
  logic [7:0] drop_inc;

  assign v_rise      = vid_v & ~v_d_q;
  assign v_fall      = ~vid_v & v_d_q;
  assign h_fall      = ~vid_h & h_d_q;
  assign field_match = v_fall & (vid_f == FIELD_SEL);
  assign drop_inc    = (drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;

  // Blanking flags gate the window too, so a line cut short by vid_h stops writing at once.
  assign in_window = ~vid_h & ~vid_v &
                     (hcnt_q >= H_LO) & (hcnt_q < H_HI) &
                     (vcnt_q >= V_LO) & (vcnt_q <= V_HI);

  always_comb begin
    hcnt_d = hcnt_q;
    if (vid_h || vid_v) begin
      hcnt_d = '0;
    end else if (hcnt_q != CNT_MAX) begin
      hcnt_d = hcnt_q + 1'b1;
    end
  end

  always_comb begin
    vcnt_d = vcnt_q;
    if (v_fall) begin
      vcnt_d = '0;
    end else if (h_fall && !vid_v && (vcnt_q != CNT_MAX)) begin
      vcnt_d = vcnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    write_req_d  = write_req_q;
    write_en_d   = 1'b0;
    write_data_d = write_data_q;
    pix_cnt_d    = pix_cnt_q;
    widx_d       = widx_q;
    ridx_d       = ridx_q;
    done_d       = done_q;
    drop_d       = drop_q;
    unique case (state_q)
      StIdle: begin
        if (v_rise) begin
          state_d     = StReq;
          write_req_d = 1'b1;
        end
      end
      StReq: begin
        // Ack beats a simultaneous field start: the field is skipped, not counted as dropped.
        if (write_req_ack) begin
          write_req_d = 1'b0;
          state_d     = StArmed;
        end else if (field_match) begin
          drop_d = drop_inc;
        end
      end
      StArmed: begin
        if (field_match) begin
          state_d   = StActive;
          pix_cnt_d = '0;
        end
      end
      StActive: begin
        if (in_window) begin
          write_en_d   = 1'b1;
          write_data_d = pix_rgb;
          if (pix_cnt_q != PIX_MAX) begin
            pix_cnt_d = pix_cnt_q + 1'b1;
          end
        end
        if (v_rise) begin
          state_d     = StReq;
          write_req_d = 1'b1;
          if (pix_cnt_q == PIX_END) begin
            widx_d = widx_q + 2'd1;
            ridx_d = widx_q;
            done_d = done_q + 16'd1;
          end else begin
            drop_d = drop_inc;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge bt656_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      h_d_q        <= 1'b1;
      v_d_q        <= 1'b1;
      hcnt_q       <= '0;
      vcnt_q       <= '0;
      pix_cnt_q    <= '0;
      write_req_q  <= 1'b0;
      write_en_q   <= 1'b0;
      write_data_q <= '0;
      widx_q       <= '0;
      ridx_q       <= '0;
      done_q       <= '0;
      drop_q       <= '0;
    end else begin
      state_q      <= state_d;
      h_d_q        <= vid_h;
      v_d_q        <= vid_v;
      hcnt_q       <= hcnt_d;
      vcnt_q       <= vcnt_d;
      pix_cnt_q    <= pix_cnt_d;
      write_req_q  <= write_req_d;
      write_en_q   <= write_en_d;
      write_data_q <= write_data_d;
      widx_q       <= widx_d;
      ridx_q       <= ridx_d;
      done_q       <= done_d;
      drop_q       <= drop_d;
    end
  end

  assign write_req        = write_req_q;
  assign write_en         = write_en_q;
  assign write_data       = write_data_q;
  assign write_addr_index = widx_q;
  assign read_addr_index  = ridx_q;
  assign frames_done      = done_q;
  assign frames_dropped   = drop_q;

endmodule
